// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter with per-port grant lock for multi-beat accesses.
// Optional ARB_ROUND_ROBIN_EN: round-robin IDLE ties; otherwise port 0 has fixed priority.
module sram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_write_data,
   input  logic              m0_read_en,
   input  logic              m0_write_en,
   input  logic              m0_lock,
   output logic [DATA_W-1:0] m0_read_data,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_write_data,
   input  logic              m1_read_en,
   input  logic              m1_write_en,
   input  logic              m1_lock,
   output logic [DATA_W-1:0] m1_read_data,
   output logic              m1_ready,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_write_data,
   output logic              sram_read_en,
   output logic              sram_write_en,
   input  logic [DATA_W-1:0] sram_read_data,
   input  logic              sram_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_grant, last_grant_nxt;
   logic   req0, req1, tie_to1, pick1;

   assign req0 = m0_read_en | m0_write_en;
   assign req1 = m1_read_en | m1_write_en;

`ifdef ARB_ROUND_ROBIN_EN
   assign tie_to1 = ~last_grant;
`else
   assign tie_to1 = 1'b0;
`endif

   assign pick1 = req1 & (~req0 | tie_to1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      last_grant_nxt  = last_grant;
      sram_address    = '0;
      sram_write_data = '0;
      sram_read_en    = 1'b0;
      sram_write_en   = 1'b0;
      m0_ready        = 1'b0;
      m1_ready        = 1'b0;
      m0_read_data    = '0;
      m1_read_data    = '0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt      = pick1 ? GRANT1 : GRANT0;
               last_grant_nxt = pick1;
            end
         end
         GRANT0: begin
            sram_address    = m0_address;
            sram_write_data = m0_write_data;
            sram_write_en   = m0_write_en;
            sram_read_en    = m0_read_en & ~m0_write_en;
            m0_ready        = sram_ready;
            m0_read_data    = sram_ready ? sram_read_data : '0;
            // A held lock keeps the grant even with no request presented.
            if ((sram_ready || !req0) && !m0_lock) state_nxt = IDLE;
         end
         GRANT1: begin
            sram_address    = m1_address;
            sram_write_data = m1_write_data;
            sram_write_en   = m1_write_en;
            sram_read_en    = m1_read_en & ~m1_write_en;
            m1_ready        = sram_ready;
            m1_read_data    = sram_ready ? sram_read_data : '0;
            if ((sram_ready || !req1) && !m1_lock) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level ownership model.
module tb_sram_arbiter;
   logic        clk, rst;
   logic [31:0] m0_address, m0_write_data, m0_read_data;
   logic        m0_read_en, m0_write_en, m0_lock, m0_ready;
   logic [31:0] m1_address, m1_write_data, m1_read_data;
   logic        m1_read_en, m1_write_en, m1_lock, m1_ready;
   logic [31:0] sram_address, sram_write_data, sram_read_data;
   logic        sram_read_en, sram_write_en, sram_ready;

   int total = 0;
   int bad   = 0;

   sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_read_en(m0_read_en),
      .m0_write_en(m0_write_en), .m0_lock(m0_lock), .m0_read_data(m0_read_data), .m0_ready(m0_ready),
      .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_read_en(m1_read_en),
      .m1_write_en(m1_write_en), .m1_lock(m1_lock), .m1_read_data(m1_read_data), .m1_ready(m1_ready),
      .sram_address(sram_address), .sram_write_data(sram_write_data), .sram_read_en(sram_read_en),
      .sram_write_en(sram_write_en), .sram_read_data(sram_read_data), .sram_ready(sram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the SRAM (-1 none, 0 or 1) and who was last granted.
   int mod_own, mod_last;

   function automatic bit preq(int p);
      return (p == 0) ? (m0_read_en | m0_write_en) : (m1_read_en | m1_write_en);
   endfunction

   function automatic bit plock(int p);
      return (p == 0) ? m0_lock : m1_lock;
   endfunction

   function automatic int pick(bit r0, bit r1, int last);
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
         return (last == 0) ? 1 : 0;
`else
         return 0;
`endif
      end
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mod_own  <= -1;
         mod_last <= 1;
      end else if (mod_own == -1) begin
         mod_own <= pick(preq(0), preq(1), mod_last);
         if (pick(preq(0), preq(1), mod_last) >= 0) mod_last <= pick(preq(0), preq(1), mod_last);
      end else if ((sram_ready || !preq(mod_own)) && !plock(mod_own)) begin
         mod_own <= -1;
      end
   end

   task automatic idle_inputs;
      m0_address = 0; m0_write_data = 0; m0_read_en = 0; m0_write_en = 0; m0_lock = 0;
      m1_address = 0; m1_write_data = 0; m1_read_en = 0; m1_write_en = 0; m1_lock = 0;
      sram_read_data = 0; sram_ready = 0;
   endtask

   task automatic cyc;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b0;
      m0_read_en = 1; m1_write_en = 1; sram_ready = 1; sram_read_data = 32'hFFFF_FFFF;
      #1;
      total++;
      if ({m0_read_data, m1_read_data, m0_ready, m1_ready, sram_address, sram_write_data,
           sram_read_en, sram_write_en} !== '0) begin
         bad++; $display("FAIL reset_outputs: some output nonzero in reset (en=%b/%b rdy=%b/%b)",
                         sram_read_en, sram_write_en, m0_ready, m1_ready);
      end
      @(posedge clk); #1;
      total++;
      if ({sram_read_en, sram_write_en, m0_ready, m1_ready} !== 4'b0) begin
         bad++; $display("FAIL reset_held: en/ready=%b required 0000",
                         {sram_read_en, sram_write_en, m0_ready, m1_ready});
      end
      idle_inputs();
      sram_ready = 1; sram_read_data = 32'h5555_AAAA;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({m0_ready, m1_ready, m0_read_data, m1_read_data} !== '0) begin
         bad++; $display("FAIL idle_ready_ignored: ready=%b%b required 00", m0_ready, m1_ready);
      end
      cyc();
      sram_ready = 0;
   endtask

   task automatic test_single_read;
      do_reset();
      m0_address = 32'h400; m0_read_en = 1;
      @(negedge clk);
      total++;
      if (sram_read_en !== 1'b0) begin
         bad++; $display("FAIL single_arb_cycle: sram_read_en=%b required 0", sram_read_en);
      end
      for (int c = 1; c <= 3; c++) begin
         cyc();
         @(negedge clk);
         total++;
         if ({sram_read_en, sram_write_en, sram_address, m0_ready} !== {2'b10, 32'h400, 1'b0}) begin
            bad++; $display("FAIL single_grant c%0d: re=%b we=%b addr=%h rdy=%b required re=1 addr=400 rdy=0",
                            c, sram_read_en, sram_write_en, sram_address, m0_ready);
         end
      end
      cyc();
      sram_ready = 1; sram_read_data = 32'hDEAD_BEEF;
      @(negedge clk);
      total++;
      if ({m0_ready, m0_read_data, m1_ready} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
         bad++; $display("FAIL single_done: m0_ready=%b data=%h m1_ready=%b required 1 deadbeef 0",
                         m0_ready, m0_read_data, m1_ready);
      end
      cyc();
      sram_ready = 0; m0_read_en = 0;
      @(negedge clk);
      total++;
      if (sram_read_en !== 1'b0) begin
         bad++; $display("FAIL single_release: sram_read_en=%b required 0", sram_read_en);
      end
   endtask

   task automatic test_tie;
      int order[$];
      int exp_order[4];
      bit pe, pr;
      bit got1;
      do_reset();
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      m0_address = 32'h10; m1_address = 32'h20; m0_read_en = 1; m1_read_en = 1;
      pe = 0; pr = 0;
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
         @(negedge clk);
         if (m0_ready) order.push_back(0);
         if (m1_ready) order.push_back(1);
         pe = sram_read_en; pr = sram_ready;
         cyc();
         sram_ready = pe && !pr;
      end
      total++;
      if (order.size() < 4) begin
         bad++; $display("FAIL tie_timeout: %0d grants seen required 4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
               bad++; $display("FAIL tie_order[%0d]: port %0d required %0d", i, order[i], exp_order[i]);
            end
         end
      end
      // With m0 quiet, m1 must be served.
      m0_read_en = 0; sram_ready = 0; pe = 0; pr = 0; got1 = 0;
      for (int c = 0; c < 12 && !got1; c++) begin
         @(negedge clk);
         if (m1_ready) got1 = 1;
         pe = sram_read_en; pr = sram_ready;
         cyc();
         sram_ready = pe && !pr;
      end
      total++;
      if (!got1) begin
         bad++; $display("FAIL tie_m1_served: m1_ready=0 required 1 within 12 cycles");
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_lock_fill;
      do_reset();
      m1_address = 32'h900; m1_read_en = 1;
      m0_address = 32'h400; m0_read_en = 1; m0_lock = 1;
      @(negedge clk);
      total++;
      if (sram_read_en !== 1'b0) begin
         bad++; $display("FAIL lock_arb: sram_read_en=%b required 0", sram_read_en);
      end
      cyc();
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_address} !== {1'b1, 32'h400}) begin
         bad++; $display("FAIL lock_first: re=%b addr=%h required 1 400", sram_read_en, sram_address);
      end
      cyc();
      sram_ready = 1; sram_read_data = 32'h1111_1111;
      @(negedge clk);
      total++;
      if ({m0_ready, m0_read_data, m1_ready} !== {1'b1, 32'h1111_1111, 1'b0}) begin
         bad++; $display("FAIL lock_beat0: m0_ready=%b data=%h m1_ready=%b required 1 11111111 0",
                         m0_ready, m0_read_data, m1_ready);
      end
      cyc();
      sram_ready = 0; m0_address = 32'h404;
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_address} !== {1'b1, 32'h404}) begin
         bad++; $display("FAIL lock_no_bubble: re=%b addr=%h required 1 404", sram_read_en, sram_address);
      end
      cyc();
      sram_ready = 1; sram_read_data = 32'h2222_2222; m0_lock = 0;
      @(negedge clk);
      total++;
      if ({m0_ready, m0_read_data, m1_ready, sram_address} !== {1'b1, 32'h2222_2222, 1'b0, 32'h404}) begin
         bad++; $display("FAIL lock_beat1: m0_ready=%b data=%h m1_ready=%b addr=%h required 1 22222222 0 404",
                         m0_ready, m0_read_data, m1_ready, sram_address);
      end
      cyc();
      sram_ready = 0; m0_read_en = 0;
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_write_en} !== 2'b00) begin
         bad++; $display("FAIL lock_idle_after: en=%b%b required 00", sram_read_en, sram_write_en);
      end
      cyc();
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_address} !== {1'b1, 32'h900}) begin
         bad++; $display("FAIL lock_m1_grant: re=%b addr=%h required 1 900", sram_read_en, sram_address);
      end
      cyc();
      sram_ready = 1; sram_read_data = 32'h3333_3333;
      @(negedge clk);
      total++;
      if ({m1_ready, m1_read_data, m0_ready} !== {1'b1, 32'h3333_3333, 1'b0}) begin
         bad++; $display("FAIL lock_m1_done: m1_ready=%b data=%h m0_ready=%b required 1 33333333 0",
                         m1_ready, m1_read_data, m0_ready);
      end
      cyc();
      idle_inputs();
   endtask

   task automatic test_write_read;
      do_reset();
      m1_address = 32'h800; m1_write_data = 32'h1234_5678; m1_write_en = 1; m1_read_en = 1;
      cyc();
      m0_address = 32'hC00; m0_read_en = 1;
      @(negedge clk);
      total++;
      if ({sram_write_en, sram_read_en, sram_address, sram_write_data} !== {2'b10, 32'h800, 32'h1234_5678}) begin
         bad++; $display("FAIL wr_grant: we=%b re=%b addr=%h wd=%h required 1 0 800 12345678",
                         sram_write_en, sram_read_en, sram_address, sram_write_data);
      end
      cyc();
      sram_ready = 1; sram_read_data = 32'hABCD_0000;
      @(negedge clk);
      total++;
      if ({m1_ready, m0_ready, m0_read_data, sram_read_en, sram_write_en} !== {2'b10, 32'h0, 2'b01}) begin
         bad++; $display("FAIL wr_done: m1_ready=%b m0_ready=%b m0_data=%h re=%b we=%b required 1 0 0 0 1",
                         m1_ready, m0_ready, m0_read_data, sram_read_en, sram_write_en);
      end
      cyc();
      sram_ready = 0; m1_write_en = 0; m1_read_en = 0;
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_write_en} !== 2'b00) begin
         bad++; $display("FAIL wr_idle: en=%b%b required 00", sram_read_en, sram_write_en);
      end
      cyc();
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_write_en, sram_address} !== {2'b10, 32'hC00}) begin
         bad++; $display("FAIL rd_after_wr: re=%b we=%b addr=%h required 1 0 c00",
                         sram_read_en, sram_write_en, sram_address);
      end
      cyc();
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_mid;
      do_reset();
      m1_address = 32'h500; m1_read_en = 1;
      cyc();
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_address} !== {1'b1, 32'h500}) begin
         bad++; $display("FAIL rstmid_grant1: re=%b addr=%h required 1 500", sram_read_en, sram_address);
      end
      m0_address = 32'h600; m0_read_en = 1; sram_ready = 1; sram_read_data = 32'h7777_7777;
      rst = 1'b0;
      #1;
      total++;
      if ({m0_read_data, m1_read_data, m0_ready, m1_ready, sram_address, sram_write_data,
           sram_read_en, sram_write_en} !== '0) begin
         bad++; $display("FAIL rstmid_outputs: re=%b addr=%h m1_ready=%b required all 0",
                         sram_read_en, sram_address, m1_ready);
      end
      cyc();
      sram_ready = 0;
      rst = 1'b1;
      cyc();
      @(negedge clk);
      total++;
      if ({sram_read_en, sram_address} !== {1'b1, 32'h600}) begin
         bad++; $display("FAIL rstmid_tie_port0: re=%b addr=%h required 1 600", sram_read_en, sram_address);
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_random;
      bit          pend[2], w[2], rb[2], lk[2];
      logic [31:0] a[2], wd[2];
      int          issued[2], done[2];
      int          cnt, lat, own;
      logic [67:0] obs, expv;
      logic [31:0] e_addr, e_wd;
      bit          e_re, e_we;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; issued[p] = 0; done[p] = 0; a[p] = 0; wd[p] = 0; w[p] = 0; rb[p] = 0; lk[p] = 0;
      end
      cnt = 0; lat = $urandom_range(0, 3);
      for (int c = 0; c < 700; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && c < 640 && $urandom_range(0, 2) == 0) begin
               pend[p] = 1; issued[p]++;
               a[p] = $urandom() & 32'hFFFF_FFFC; wd[p] = $urandom();
               w[p] = 1'($urandom_range(0, 1));
               rb[p] = w[p] ? 1'($urandom_range(0, 1)) : 1'b1;
               lk[p] = ($urandom_range(0, 3) == 0);
            end
         end
         m0_address = a[0]; m0_write_data = wd[0];
         m0_write_en = pend[0] && w[0]; m0_read_en = pend[0] && rb[0];
         m0_lock = pend[0] ? lk[0] : ($urandom_range(0, 4) == 0);
         m1_address = a[1]; m1_write_data = wd[1];
         m1_write_en = pend[1] && w[1]; m1_read_en = pend[1] && rb[1];
         m1_lock = pend[1] ? lk[1] : ($urandom_range(0, 4) == 0);
         sram_read_data = $urandom();
         sram_ready = (cnt > lat) || (mod_own == -1 && $urandom_range(0, 9) == 0);
         @(negedge clk);
         own = mod_own;
         e_addr = 0; e_wd = 0; e_re = 0; e_we = 0;
         if (own >= 0) begin
            e_addr = a[own]; e_wd = wd[own];
            e_we = pend[own] && w[own];
            e_re = pend[own] && rb[own] && !w[own];
         end
         expv = {e_addr, e_wd, e_re, e_we, (own == 0) && sram_ready, (own == 1) && sram_ready};
         obs  = {sram_address, sram_write_data, sram_read_en, sram_write_en, m0_ready, m1_ready};
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL rand c%0d: obs=%h required %h (owner %0d)", c, obs, expv, own);
         end
         if (own >= 0 && sram_ready) begin
            total++;
            if (((own == 0) ? m0_read_data : m1_read_data) !== sram_read_data) begin
               bad++; $display("FAIL rand_rdata c%0d: port %0d data=%h required %h", c, own,
                               (own == 0) ? m0_read_data : m1_read_data, sram_read_data);
            end
            if (pend[own]) begin
               pend[own] = 0; done[own]++;
            end
         end
         total++;
         if ((own != 0 && m0_read_data !== 0) || (own != 1 && m1_read_data !== 0)) begin
            bad++; $display("FAIL rand_idle_data c%0d: m0=%h m1=%h required 0 on non-granted port",
                            c, m0_read_data, m1_read_data);
         end
         if (sram_ready) begin
            cnt = 0; lat = $urandom_range(0, 3);
         end else if (e_re || e_we) cnt++;
         else cnt = 0;
         cyc();
      end
      for (int p = 0; p < 2; p++) begin
         total++;
         if (issued[p] !== done[p]) begin
            bad++; $display("FAIL rand_drain port%0d: completed %0d required %0d", p, done[p], issued[p]);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single_read();
      test_tie();
      test_lock_fill();
      test_write_read();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
